// File: rtl/seg_display_mux.sv
// seg_display_mux
// Time-multiplexed driver for a common-anode seven-segment display.
// Per-digit decimal point and blanking, leading-zero suppression,
// 8-level PWM brightness, and double-buffered, frame-synchronous updates.
// All pin outputs (an, seg, dp) are registered together so they never skew.

module seg_display_mux #(
    parameter int DIGITS = 4,
    parameter int DIV    = 25000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   num,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  load,
    input  logic                  lz_en,
    input  logic [2:0]            bright,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  pending
);

    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(DIGITS);
    localparam logic [CW-1:0] CntLast = CW'(DIV - 1);
    localparam logic [IW-1:0] IdxLast = IW'(DIGITS - 1);

    // Slot timing state
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;

    // Shadow register: written by load, not yet visible
    logic [4*DIGITS-1:0]   shadowNum_q, shadowNum_d;
    logic [DIGITS-1:0]     shadowDp_q, shadowDp_d;
    logic [DIGITS-1:0]     shadowBlank_q, shadowBlank_d;

    // Display register: what is actually being scanned out
    logic [4*DIGITS-1:0]   dispNum_q, dispNum_d;
    logic [DIGITS-1:0]     dispDp_q, dispDp_d;
    logic [DIGITS-1:0]     dispBlank_q, dispBlank_d;

    logic                  pending_q, pending_d;

    // Registered pin drivers
    logic [DIGITS-1:0]     an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    // Intermediate decode of the currently scanned digit
    logic                  slotEnd;
    logic                  frameEnd;
    logic                  transfer;
    logic [3:0]            curNib;
    logic                  curDp;
    logic                  curBlank;
    logic                  allZero;
    logic                  lzHit;
    logic                  suppress;
    logic [31:0]           litLen;
    logic                  inWindow;

    // Hex nibble to active-low {g,f,e,d,c,b,a} glyph
    function automatic logic [6:0] glyph(input logic [3:0] value);
        logic [6:0] g;
        case (value)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    // Slot/digit counters, load capture, and end-of-frame shadow-to-display transfer
    always_comb begin
        cnt_d         = cnt_q + CW'(1);
        idx_d         = idx_q;
        shadowNum_d   = shadowNum_q;
        shadowDp_d    = shadowDp_q;
        shadowBlank_d = shadowBlank_q;
        dispNum_d     = dispNum_q;
        dispDp_d      = dispDp_q;
        dispBlank_d   = dispBlank_q;
        pending_d     = pending_q;

        slotEnd  = (cnt_q == CntLast);
        frameEnd = slotEnd && (idx_q == IdxLast);
        transfer = frameEnd && pending_q;

        if (slotEnd) begin
            cnt_d = '0;
            idx_d = (idx_q == IdxLast) ? '0 : idx_q + IW'(1);
        end

        // Transfer reads the old shadow; a coincident load refills it and keeps pending set
        if (transfer) begin
            dispNum_d   = shadowNum_q;
            dispDp_d    = shadowDp_q;
            dispBlank_d = shadowBlank_q;
            pending_d   = 1'b0;
        end

        if (load) begin
            shadowNum_d   = num;
            shadowDp_d    = dp_in;
            shadowBlank_d = blank_in;
            pending_d     = 1'b1;
        end
    end

    // Decode the scanned digit into next anode/segment/dp values
    always_comb begin
        curNib   = 4'h0;
        curDp    = 1'b0;
        curBlank = 1'b0;
        allZero  = 1'b1;
        lzHit    = 1'b0;
        an_d     = '1;

        // Walk from the most significant digit down so allZero covers idx and above
        for (int k = DIGITS - 1; k >= 0; k--) begin
            allZero = allZero && (dispNum_q[4*k +: 4] == 4'h0);
            if (IW'(k) == idx_q) begin
                lzHit    = allZero;
                curNib   = dispNum_q[4*k +: 4];
                curDp    = dispDp_q[k];
                curBlank = dispBlank_q[k];
            end
        end

        suppress = curBlank || (lz_en && (idx_q != '0) && lzHit);

        // cnt==0 is the dark dead cycle between digits
        litLen   = ((32'(bright) + 32'd1) * 32'(DIV)) >> 3;
        inWindow = (cnt_q != '0) && (32'(cnt_q) < litLen);

        for (int k = 0; k < DIGITS; k++) begin
            if ((IW'(k) == idx_q) && inWindow && !suppress) begin
                an_d[k] = 1'b0;
            end
        end

        seg_d = suppress ? 7'h7F : glyph(curNib);
        dp_d  = suppress ? 1'b1  : ~curDp;
    end

    // State and output registers; reset darkens the display immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            shadowNum_q   <= '0;
            shadowDp_q    <= '0;
            shadowBlank_q <= '0;
            dispNum_q     <= '0;
            dispDp_q      <= '0;
            dispBlank_q   <= '0;
            pending_q     <= 1'b0;
            an_q          <= '1;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadowNum_q   <= shadowNum_d;
            shadowDp_q    <= shadowDp_d;
            shadowBlank_q <= shadowBlank_d;
            dispNum_q     <= dispNum_d;
            dispDp_q      <= dispDp_d;
            dispBlank_q   <= dispBlank_d;
            pending_q     <= pending_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign an      = an_q;
    assign seg     = seg_q;
    assign dp      = dp_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed testbench for seg_display_mux with DIGITS=4, DIV=16 (64-cycle frame).
// edgeCount counts rising edges since the last reset release; after edge E the
// pins reflect internal state number E-1 (cnt=(E-1)%16, idx=((E-1)/16)%4).

module tb_seg_display_mux;

    logic        clock;
    logic        reset;
    logic [15:0] num;
    logic [3:0]  dpIn;
    logic [3:0]  blankIn;
    logic        load;
    logic        lzEn;
    logic [2:0]  bright;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        pending;

    int checks;
    int errors;
    int edgeCount;
    int litCount;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GF = 7'b0001110;
    localparam logic [6:0] OFF = 7'h7F;

    seg_display_mux #(.DIGITS(4), .DIV(16)) dut (
        .clk      (clock),
        .rst      (reset),
        .num      (num),
        .dp_in    (dpIn),
        .blank_in (blankIn),
        .load     (load),
        .lz_en    (lzEn),
        .bright   (bright),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .pending  (pending)
    );

    // 10-unit clock; rising edges at 5, 15, ... and sampling on falling edges
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to the falling edge following rising edge number target
    task automatic stepTo(input int target);
        while (edgeCount < target) begin
            @(negedge clock);
            edgeCount++;
        end
    endtask

    // Present a load for exactly one rising edge
    task automatic applyStimulus(input logic [15:0] n, input logic [3:0] d, input logic [3:0] b);
        num     = n;
        dpIn    = d;
        blankIn = b;
        load    = 1'b1;
        stepTo(edgeCount + 1);
        load    = 1'b0;
    endtask

    // Compare all four outputs against hand-computed values
    task automatic checkOutput(input string tag, input logic [3:0] expAn, input logic [6:0] expSeg,
                               input logic expDp, input logic expPend);
        checks++;
        assert (an === expAn) else begin
            errors++;
            $error("FAIL %s an observed=%b expected=%b", tag, an, expAn);
        end
        checks++;
        assert (seg === expSeg) else begin
            errors++;
            $error("FAIL %s seg observed=%b expected=%b", tag, seg, expSeg);
        end
        checks++;
        assert (dp === expDp) else begin
            errors++;
            $error("FAIL %s dp observed=%b expected=%b", tag, dp, expDp);
        end
        checks++;
        assert (pending === expPend) else begin
            errors++;
            $error("FAIL %s pending observed=%b expected=%b", tag, pending, expPend);
        end
    endtask

    // Compare a counted quantity
    task automatic checkCount(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Linear sequence of directed steps
    initial begin
        checks    = 0;
        errors    = 0;
        edgeCount = 0;
        reset     = 1'b1;
        num       = 16'h0000;
        dpIn      = 4'b0000;
        blankIn   = 4'b0000;
        load      = 1'b0;
        lzEn      = 1'b0;
        bright    = 3'd7;

        repeat (3) @(negedge clock);
        checkOutput("reset_state", 4'b1111, OFF, 1'b1, 1'b0);

        // Blank frame: each slot dark at cnt 0 then lit for 15 cycles
        reset = 1'b0;
        edgeCount = 0;
        stepTo(1);  checkOutput("dig0_cnt0_dark", 4'b1111, G0, 1'b1, 1'b0);
        stepTo(2);  checkOutput("dig0_first_lit", 4'b1110, G0, 1'b1, 1'b0);
        stepTo(16); checkOutput("dig0_cnt15_lit", 4'b1110, G0, 1'b1, 1'b0);
        stepTo(17); checkOutput("dig1_cnt0_dark", 4'b1111, G0, 1'b1, 1'b0);
        stepTo(18); checkOutput("dig1_lit",       4'b1101, G0, 1'b1, 1'b0);
        stepTo(34); checkOutput("dig2_lit",       4'b1011, G0, 1'b1, 1'b0);
        stepTo(50); checkOutput("dig3_lit",       4'b0111, G0, 1'b1, 1'b0);
        stepTo(66); checkOutput("wrap_dig0_lit",  4'b1110, G0, 1'b1, 1'b0);

        // Tear-free load mid-slot of digit 1; transfer at edge 128
        stepTo(85);
        applyStimulus(16'h12AF, 4'b0000, 4'b0000);
        checkOutput("load_pending",      4'b1101, G0, 1'b1, 1'b1);
        stepTo(127); checkOutput("old_until_frame_end", 4'b0111, G0, 1'b1, 1'b1);
        stepTo(128); checkOutput("transfer_edge",       4'b0111, G0, 1'b1, 1'b0);
        stepTo(129); checkOutput("new_dig0_dead",       4'b1111, GF, 1'b1, 1'b0);
        stepTo(130); checkOutput("new_dig0_F",          4'b1110, GF, 1'b1, 1'b0);
        stepTo(146); checkOutput("new_dig1_A",          4'b1101, GA, 1'b1, 1'b0);
        stepTo(178); checkOutput("new_dig3_1",          4'b0111, G1, 1'b1, 1'b0);

        // Load collision: 0003 waits in shadow, 0004 arrives on the transfer edge 256
        stepTo(200);
        applyStimulus(16'h0003, 4'b0000, 4'b0000);
        stepTo(255);
        applyStimulus(16'h0004, 4'b0000, 4'b0000);
        checkOutput("collision_edge",   4'b0111, G1, 1'b1, 1'b1);
        stepTo(258); checkOutput("collision_old_shown", 4'b1110, G3, 1'b1, 1'b1);
        stepTo(321); checkOutput("collision_new_frame", 4'b1111, G4, 1'b1, 1'b0);

        // Leading-zero suppression with 0050, transfer at edge 384
        lzEn = 1'b1;
        stepTo(330);
        applyStimulus(16'h0050, 4'b0000, 4'b0000);
        stepTo(386); checkOutput("lz_dig0_0", 4'b1110, G0, 1'b1, 1'b0);
        stepTo(402); checkOutput("lz_dig1_5", 4'b1101, G5, 1'b1, 1'b0);
        stepTo(418); checkOutput("lz_dig2_off", 4'b1111, OFF, 1'b1, 1'b0);
        stepTo(434); checkOutput("lz_dig3_off", 4'b1111, OFF, 1'b1, 1'b0);

        // All-zero value: only digit 0 lights; transfer at edge 448
        applyStimulus(16'h0000, 4'b0000, 4'b0000);
        stepTo(450); checkOutput("zero_dig0_lit", 4'b1110, G0, 1'b1, 1'b0);
        stepTo(466); checkOutput("zero_dig1_off", 4'b1111, OFF, 1'b1, 1'b0);

        // Brightness 1: lit_len 4, so cnt 1..3 lit in the digit-0 slot (edges 513..528)
        bright = 3'd1;
        litCount = 0;
        for (int e = 513; e <= 528; e++) begin
            stepTo(e);
            if (an[0] == 1'b0) litCount++;
        end
        checkCount("bright1_lit_cycles", litCount, 3);

        // Drop to brightness 0 after the first lit cycle of the next digit-0 slot
        litCount = 0;
        for (int e = 577; e <= 592; e++) begin
            stepTo(e);
            if (an[0] == 1'b0) litCount++;
            if (e == 578) bright = 3'd0;
        end
        checkCount("bright0_midslot_lit_cycles", litCount, 1);
        bright = 3'd7;
        lzEn   = 1'b0;

        // Decimal point on digit 2, digit 0 blanked; transfer at edge 640
        applyStimulus(16'h1234, 4'b0100, 4'b0001);
        stepTo(641); checkOutput("blank_dig0_dead", 4'b1111, OFF, 1'b1, 1'b0);
        stepTo(642); checkOutput("blank_dig0_dark", 4'b1111, OFF, 1'b1, 1'b0);
        stepTo(658); checkOutput("dp_dig1_off",     4'b1101, G3,  1'b1, 1'b0);
        stepTo(674); checkOutput("dp_dig2_on",      4'b1011, G2,  1'b0, 1'b0);
        stepTo(690); checkOutput("dp_dig3_off",     4'b0111, G1,  1'b1, 1'b0);

        // Asynchronous reset mid-slot with an update pending
        applyStimulus(16'hFFFF, 4'b1111, 4'b0000);
        stepTo(692); checkOutput("pre_reset_lit", 4'b0111, G1, 1'b1, 1'b1);
        #2 reset = 1'b1;
        #1 checkOutput("async_reset", 4'b1111, OFF, 1'b1, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        edgeCount = 0;
        stepTo(2); checkOutput("after_reset_discarded", 4'b1110, G0, 1'b1, 1'b0);
        stepTo(66); checkOutput("after_reset_no_transfer", 4'b1110, G0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_display_mux.md
# seg_display_mux

Parametrised, time-multiplexed driver for a common-anode seven-segment display of DIGITS hexadecimal digits, with per-digit decimal point, per-digit blanking, leading-zero suppression, 8-level PWM brightness and tear-free frame-synchronous updates. It sits between the CPU's register/debug datapath and the board's anode and segment pins. It divides the system clock internally, so no external enable is needed.

## Interface
- DIGITS, default 4: number of digits multiplexed, range 2..8.
- DIV, default 25000: clock cycles per digit slot, range 16 or more.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- num  in  4*DIGITS  hex value; digit k is num[4k+3:4k], and digit 0 is the rightmost.
- dp_in  in  DIGITS  decimal point request per digit, 1 = lit.
- blank_in  in  DIGITS  forced blank per digit, 1 = dark.
- load  in  1  single-cycle strobe that captures num, dp_in and blank_in.
- lz_en  in  1  leading-zero suppression enable; sampled live.
- bright  in  3  brightness level: 0 is dimmest, 7 is full; sampled live.
- an  out  DIGITS  anodes, active-low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- pending  out  1  high while a captured update has not yet been shown.

## Operation
- **State:** the block holds
  - slot counter cnt, range 0..DIV-1;
  - digit index idx, range 0..DIGITS-1;
  - a shadow register, which takes load data;
  - a display register, which is what gets shown;
  - a pending flag.
- **Counting:** each cycle cnt increments. When cnt==DIV-1, cnt wraps to 0 and idx advances. idx wraps from DIGITS-1 to 0. A full frame is DIGITS*DIV cycles.
- **Load:** when load=1, num, dp_in and blank_in are written to the shadow register and pending is set. A load while pending is already set overwrites the shadow register; the last load wins.
- **Frame transfer:** on the cycle where cnt==DIV-1, idx==DIGITS-1 and pending==1, the shadow register is copied to the display register and pending is cleared.
  - If load coincides with a transfer, the transfer copies the old shadow contents.
  - The new data then enters the shadow register and pending stays 1 until the next frame.
- **Lit window:** lit_len = ((bright+1)*DIV)>>3. The slot is lit when cnt!=0 and cnt<lit_len. cnt==0 is always dark; this is the anti-ghosting dead cycle.
- **Digit suppression:** digit idx is suppressed when either of the following holds:
  - its blank bit is set;
  - lz_en=1, idx>0, and every display-register nibble at index idx and above is 0.
  - Digit 0 is never zero-suppressed.
- **Anode drive:** an is all ones except bit idx, which is 0 when the slot is lit and the digit is not suppressed.
- **Segment and dp drive:**
  - seg gives the glyph for the nibble at idx when that digit is not suppressed; otherwise seg = 7'h7F.
  - dp = ~dp_bit[idx] when that digit is not suppressed; otherwise dp = 1.
- **Glyphs (seg, binary):**
  - 0–7: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
  - 8–F: 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- **Registered outputs:** an, seg and dp are registered together. They reflect the cnt, idx and register state of the previous cycle, so they never glitch and never skew against each other.

## Timing
- **Reset values:** cnt=0, idx=0, shadow=0, display=0, pending=0, an=all ones, seg=7'h7F, dp=1. While rst is high, no output is lit.
- **Output latency:** 1 cycle from internal state to pins.
- **First lit cycle after reset release:** the 2nd edge after release. The 1st edge moves cnt to 1; the 2nd edge drives an[0]=0. This assumes bright>0 or DIV>=16; because DIV>=16, lit_len>=2 holds at any bright value.
- **Load to display:** pending rises the cycle after load. The display register changes at the end of the current frame. The pins show new data from the following slot-0 lit window. The worst case is about DIGITS*DIV+2 cycles.
- **Reset mid-frame:** all state clears immediately, the pending update is discarded, and outputs go dark asynchronously.
- **bright and lz_en changes:** take effect on the next cycle, even mid-slot.

## Test plan
- **Reset and blank frame:** DIGITS=4, DIV=16, bright=7, no load. Release reset.
  - Required: an cycles 1110→1101→1011→0111, each digit dark at cnt==0 and lit for 15 cycles, seg=1000000 throughout.
- **Tear-free load:** load num=16'h12AF mid-slot of digit 1.
  - Required: pending=1 and the display still shows 0000 until the frame ends; then digit 0 shows 0001110 (F) and pending=0.
- **Load collision:** pulse load on the transfer cycle.
  - Required: the older shadow value is displayed; pending stays 1 and the new value appears one frame later.
- **Leading-zero suppression:** lz_en=1, num=16'h0050.
  - Required: digits 3 and 2 have an bit=1 and seg=7F; digits 1 and 0 show 5 and 0.
  - With num=0, only digit 0 lights.
- **Brightness:** bright=1, DIV=16, so lit_len=4.
  - Required: per slot, an bit is low for exactly 3 cycles (cnt 1..3).
  - Changing to bright=0 mid-slot gives lit_len=2, and at most 1 cycle stays lit.
- **Decimal point and blank mask:** dp_in=4'b0100, blank_in=4'b0001.
  - Required: dp=0 only during digit 2's lit window; digit 0 stays fully dark.
- **Asynchronous reset mid-slot:** assert rst.
  - Required: the same cycle, an=all ones and pending=0, without waiting for a clock edge.
